// File: rtl/axis_pkt_arbiter_n.sv
// Packet-granular N-channel AXI-Stream arbiter with round-robin or fixed priority.
// Holds a grant for a whole packet and drives the merged stream from a register stage.
module axis_pkt_arbiter_n #(
  parameter int    P_CHANNELS = 2,
  parameter int    P_DATA_W   = 64,
  parameter int    P_USER_W   = 80,
  parameter string P_MODE     = "RR",
  localparam int   KW         = P_DATA_W / 8,
  localparam int   CW         = ($clog2(P_CHANNELS) > 1) ? $clog2(P_CHANNELS) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [P_CHANNELS*P_DATA_W-1:0] s_axis_data,
  input  logic [P_CHANNELS*P_USER_W-1:0] s_axis_user,
  input  logic [P_CHANNELS*KW-1:0]       s_axis_keep,
  input  logic [P_CHANNELS-1:0]          s_axis_last,
  input  logic [P_CHANNELS-1:0]          s_axis_valid,
  output logic [P_CHANNELS-1:0]          s_axis_ready,
  output logic [P_DATA_W-1:0]            m_axis_data,
  output logic [P_USER_W-1:0]            m_axis_user,
  output logic [KW-1:0]                  m_axis_keep,
  output logic                           m_axis_last,
  output logic                           m_axis_valid,
  input  logic                           m_axis_ready,
  output logic [CW-1:0]                  o_grant_ch,
  output logic                           o_busy
);

  localparam bit FIXED = (P_MODE == "FIXED");

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        grant_ch, rr_ptr, winner;
  logic                 found, accept, out_ready;
  int unsigned          idx;
  logic [P_DATA_W-1:0]  sel_data;
  logic [P_USER_W-1:0]  sel_user;
  logic [KW-1:0]        sel_keep;
  logic                 sel_last, sel_valid;

  // Search order starts one past the last grant (RR) or at channel 0 (FIXED).
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < P_CHANNELS; i++) begin
      idx = FIXED ? i : (32'(rr_ptr) + i + 1) % P_CHANNELS;
      if (!found && s_axis_valid[idx[CW-1:0]]) begin
        found  = 1'b1;
        winner = idx[CW-1:0];
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_user  = '0;
    sel_keep  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int unsigned c = 0; c < P_CHANNELS; c++) begin
      if (grant_ch == CW'(c)) begin
        sel_data  = s_axis_data[c*P_DATA_W +: P_DATA_W];
        sel_user  = s_axis_user[c*P_USER_W +: P_USER_W];
        sel_keep  = s_axis_keep[c*KW +: KW];
        sel_last  = s_axis_last[c];
        sel_valid = s_axis_valid[c];
      end
    end
  end

  assign out_ready = ~m_axis_valid | m_axis_ready;

  always_comb begin
    state_nxt    = state;
    s_axis_ready = '0;
    accept       = 1'b0;
    unique case (state)
      IDLE: begin
        if (|s_axis_valid) state_nxt = BUSY;
      end
      BUSY: begin
        for (int unsigned c = 0; c < P_CHANNELS; c++) begin
          s_axis_ready[c] = (grant_ch == CW'(c)) & out_ready;
        end
        accept = sel_valid & out_ready;
        if (accept && sel_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= IDLE;
      grant_ch <= '0;
      rr_ptr   <= CW'(P_CHANNELS - 1);
    end else begin
      state <= state_nxt;
      if (state == IDLE && |s_axis_valid) begin
        grant_ch <= winner;
        if (!FIXED) rr_ptr <= winner;
      end
    end
  end

  // Output register: load on accept, drop valid once drained, hold under backpressure.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      m_axis_data  <= '0;
      m_axis_user  <= '0;
      m_axis_keep  <= '0;
      m_axis_last  <= 1'b0;
      m_axis_valid <= 1'b0;
    end else if (accept) begin
      m_axis_data  <= sel_data;
      m_axis_user  <= sel_user;
      m_axis_keep  <= sel_keep;
      m_axis_last  <= sel_last;
      m_axis_valid <= 1'b1;
    end else if (m_axis_ready) begin
      m_axis_valid <= 1'b0;
    end
  end

  assign o_grant_ch = grant_ch;
  assign o_busy     = (state == BUSY);

endmodule

// File: tb/tb_axis_pkt_arbiter_n.sv
// Directed bench for axis_pkt_arbiter_n: an RR and a FIXED instance share one set of
// per-channel packet sources; beats are decoded from {channel, packet, beat} data.
module tb_axis_pkt_arbiter_n;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int UW = 16;
  localparam int KW = DW / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N*DW-1:0]   s_data;
  logic [N*UW-1:0]   s_user;
  logic [N*KW-1:0]   s_keep;
  logic [N-1:0]      s_last, s_valid;
  logic              m_ready;

  logic [N-1:0]      rr_s_ready, fx_s_ready;
  logic [DW-1:0]     rr_data, fx_data;
  logic [UW-1:0]     rr_user, fx_user;
  logic [KW-1:0]     rr_keep, fx_keep;
  logic              rr_last, fx_last, rr_valid, fx_valid, rr_busy, fx_busy;
  logic [1:0]        rr_grant, fx_grant;

  axis_pkt_arbiter_n #(.P_CHANNELS(N), .P_DATA_W(DW), .P_USER_W(UW), .P_MODE("RR")) u_rr (
    .i_clk(clk), .i_rst(rst_n),
    .s_axis_data(s_data), .s_axis_user(s_user), .s_axis_keep(s_keep),
    .s_axis_last(s_last), .s_axis_valid(s_valid), .s_axis_ready(rr_s_ready),
    .m_axis_data(rr_data), .m_axis_user(rr_user), .m_axis_keep(rr_keep),
    .m_axis_last(rr_last), .m_axis_valid(rr_valid), .m_axis_ready(m_ready),
    .o_grant_ch(rr_grant), .o_busy(rr_busy));

  axis_pkt_arbiter_n #(.P_CHANNELS(N), .P_DATA_W(DW), .P_USER_W(UW), .P_MODE("FIXED")) u_fx (
    .i_clk(clk), .i_rst(rst_n),
    .s_axis_data(s_data), .s_axis_user(s_user), .s_axis_keep(s_keep),
    .s_axis_last(s_last), .s_axis_valid(s_valid), .s_axis_ready(fx_s_ready),
    .m_axis_data(fx_data), .m_axis_user(fx_user), .m_axis_keep(fx_keep),
    .m_axis_last(fx_last), .m_axis_valid(fx_valid), .m_axis_ready(m_ready),
    .o_grant_ch(fx_grant), .o_busy(fx_busy));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Source model per channel.
  int unsigned src_beat[N], src_pkt[N], src_len[N];
  bit          src_en[N], src_once[N], src_hold[N];
  logic [7:0]  src_keep[N];
  bit          bp_mode, bp_on, sel;
  bit          bp_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int unsigned bp_idx;

  // Captured output beats of the selected DUT.
  logic [63:0] oq_data[$];
  logic [15:0] oq_user[$];
  logic [7:0]  oq_keep[$];
  logic        oq_last[$];

  bit          prev_stall;
  logic [63:0] pd;
  logic [15:0] pu;
  logic [7:0]  pk;
  logic        pl;

  typedef struct {
    logic [3:0]  m1;
    logic [3:0]  m2;
    logic [1:0]  rr_g;
    logic [1:0]  fx_g;
    logic        busy;
  } vec_t;
  vec_t vt[10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_data(input int unsigned c, input int unsigned p,
                                          input int unsigned b);
    if (bp_mode) return 64'((b + 1) * 17);
    return {40'h0, 8'(c), 8'(p), 8'(b)};
  endfunction

  function automatic logic [15:0] mk_user(input logic [63:0] d);
    return d[15:0] ^ 16'hBEEF;
  endfunction

  task automatic drive_inputs();
    logic [63:0] d;
    logic        lst;
    for (int c = 0; c < N; c++) begin
      d   = mk_data(c, src_pkt[c], src_beat[c]);
      lst = (src_beat[c] == src_len[c] - 1);
      s_data[c*DW +: DW] = d;
      s_user[c*UW +: UW] = mk_user(d);
      s_keep[c*KW +: KW] = lst ? src_keep[c] : 8'hFF;
      s_last[c]          = lst;
      s_valid[c]         = src_en[c] && !src_hold[c];
    end
  endtask

  task automatic clear_sources();
    for (int c = 0; c < N; c++) begin
      src_beat[c] = 0; src_pkt[c] = 0; src_len[c] = 1;
      src_en[c] = 0; src_once[c] = 0; src_hold[c] = 0; src_keep[c] = 8'hFF;
    end
    bp_mode = 0; bp_on = 0; bp_idx = 0; m_ready = 1'b1; prev_stall = 0;
    oq_data.delete(); oq_user.delete(); oq_keep.delete(); oq_last.delete();
    drive_inputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_sources();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic start_src(input int c, input int unsigned len, input bit once,
                           input int unsigned pkt);
    src_en[c] = 1; src_len[c] = len; src_once[c] = once; src_pkt[c] = pkt; src_beat[c] = 0;
  endtask

  // One clock: observe before the edge, advance sources just after it.
  task automatic cycle();
    logic [63:0] cd; logic [15:0] cu; logic [7:0] ck; logic cl, cv;
    logic [N-1:0] rdy, fired;
    @(negedge clk);
    cv  = sel ? fx_valid : rr_valid;
    cd  = sel ? fx_data  : rr_data;
    cu  = sel ? fx_user  : rr_user;
    ck  = sel ? fx_keep  : rr_keep;
    cl  = sel ? fx_last  : rr_last;
    rdy = sel ? fx_s_ready : rr_s_ready;
    if (prev_stall)
      check("hold_stable", 128'({cv, cl, ck, cu, cd}), 128'({1'b1, pl, pk, pu, pd}));
    prev_stall = cv && !m_ready;
    pd = cd; pu = cu; pk = ck; pl = cl;
    if (cv && m_ready) begin
      oq_data.push_back(cd); oq_user.push_back(cu);
      oq_keep.push_back(ck); oq_last.push_back(cl);
    end
    fired = s_valid & rdy;
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) begin
      if (fired[c]) begin
        if (s_last[c]) begin
          src_beat[c] = 0;
          src_pkt[c]++;
          if (src_once[c]) src_en[c] = 0;
        end else begin
          src_beat[c]++;
        end
      end
    end
    if (bp_on) begin
      m_ready = bp_pat[bp_idx];
      bp_idx  = (bp_idx + 1) % 4;
    end
    drive_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned cnt;
    logic [63:0] exp_d;
    bit          seen;

    vt[0] = '{m1: 4'b0000, m2: 4'b0000, rr_g: 2'd0, fx_g: 2'd0, busy: 1'b0};
    vt[1] = '{m1: 4'b0000, m2: 4'b0110, rr_g: 2'd1, fx_g: 2'd1, busy: 1'b1};
    vt[2] = '{m1: 4'b0000, m2: 4'b1111, rr_g: 2'd0, fx_g: 2'd0, busy: 1'b1};
    vt[3] = '{m1: 4'b0000, m2: 4'b1000, rr_g: 2'd3, fx_g: 2'd3, busy: 1'b1};
    vt[4] = '{m1: 4'b0001, m2: 4'b0011, rr_g: 2'd1, fx_g: 2'd0, busy: 1'b1};
    vt[5] = '{m1: 4'b0010, m2: 4'b0011, rr_g: 2'd0, fx_g: 2'd0, busy: 1'b1};
    vt[6] = '{m1: 4'b0100, m2: 4'b1101, rr_g: 2'd3, fx_g: 2'd0, busy: 1'b1};
    vt[7] = '{m1: 4'b1000, m2: 4'b1110, rr_g: 2'd1, fx_g: 2'd1, busy: 1'b1};
    vt[8] = '{m1: 4'b0010, m2: 4'b0110, rr_g: 2'd2, fx_g: 2'd1, busy: 1'b1};
    vt[9] = '{m1: 4'b0100, m2: 4'b0100, rr_g: 2'd2, fx_g: 2'd2, busy: 1'b1};

    sel = 0;
    rst_n = 1'b0;
    clear_sources();
    #1;
    check("rst_valid", 128'({rr_valid, fx_valid}), 128'(0));
    check("rst_last_busy", 128'({rr_last, rr_busy, fx_busy}), 128'(0));
    check("rst_grant", 128'({rr_grant, fx_grant}), 128'(0));
    check("rst_payload", 128'({rr_data, rr_user, rr_keep}), 128'(0));
    check("rst_ready", 128'({rr_s_ready, fx_s_ready}), 128'(0));

    // Grant selection table: optional priming grant, then a request mask.
    for (int i = 0; i < 10; i++) begin
      do_reset();
      for (int c = 0; c < N; c++) if (vt[i].m1[c]) start_src(c, 1, 1, 0);
      drive_inputs();
      cycle();
      cycle();
      for (int c = 0; c < N; c++) if (vt[i].m2[c]) start_src(c, 1, 1, 1);
      drive_inputs();
      cycle();
      check($sformatf("tbl%0d_rr_grant", i), 128'(rr_grant), 128'(vt[i].rr_g));
      check($sformatf("tbl%0d_fx_grant", i), 128'(fx_grant), 128'(vt[i].fx_g));
      check($sformatf("tbl%0d_busy", i), 128'({rr_busy, fx_busy}), 128'({vt[i].busy, vt[i].busy}));
      check($sformatf("tbl%0d_rr_ready", i), 128'(rr_s_ready),
            128'(vt[i].busy ? (4'b0001 << vt[i].rr_g) : 4'b0000));
      check($sformatf("tbl%0d_fx_ready", i), 128'(fx_s_ready),
            128'(vt[i].busy ? (4'b0001 << vt[i].fx_g) : 4'b0000));
    end

    // RR fairness: four channels of continuous 3-beat packets.
    do_reset();
    for (int c = 0; c < N; c++) start_src(c, 3, 0, 0);
    drive_inputs();
    for (int k = 0; k < 200 && oq_data.size() < 15; k++) cycle();
    check("rr_beat_count", 128'(oq_data.size() >= 15), 128'(1));
    for (int k = 0; k < 15 && k < oq_data.size(); k++) begin
      exp_d = {40'h0, 8'((k / 3) % 4), 8'((k / 3) / 4), 8'(k % 3)};
      check($sformatf("rr_beat%0d_data", k), 128'(oq_data[k]), 128'(exp_d));
      check($sformatf("rr_beat%0d_last", k), 128'(oq_last[k]), 128'(k % 3 == 2));
    end

    // Backpressure: ready pattern 1,0,0,1 over a 4-beat packet 0x11..0x44.
    do_reset();
    bp_mode = 1;
    bp_on = 1;
    start_src(0, 4, 1, 0);
    drive_inputs();
    seen = 0;
    for (int k = 0; k < 60 && oq_data.size() < 4; k++) begin
      cycle();
      if (prev_stall) seen = 1;
    end
    repeat (6) cycle();
    check("bp_stall_seen", 128'(seen), 128'(1));
    check("bp_beat_count", 128'(oq_data.size()), 128'(4));
    for (int k = 0; k < 4 && k < oq_data.size(); k++) begin
      exp_d = 64'((k + 1) * 17);
      check($sformatf("bp_beat%0d", k), 128'({oq_last[k], oq_keep[k], oq_user[k], oq_data[k]}),
            128'({k == 3, 8'hFF, exp_d[15:0] ^ 16'hBEEF, exp_d}));
    end

    // Single-beat packet with keep 0x0F on channel 2.
    do_reset();
    start_src(2, 1, 1, 0);
    src_keep[2] = 8'h0F;
    drive_inputs();
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (rr_busy) cnt++;
    end
    check("single_busy_cycles", 128'(cnt), 128'(1));
    check("single_count", 128'(oq_data.size()), 128'(1));
    if (oq_data.size() > 0)
      check("single_beat", 128'({oq_last[0], oq_keep[0], oq_data[0]}),
            128'({1'b1, 8'h0F, 64'h0000_0000_0002_0000}));

    // Granted channel 1 stalls for 5 cycles mid-packet while channel 3 waits.
    do_reset();
    start_src(1, 4, 1, 0);
    start_src(3, 2, 0, 0);
    drive_inputs();
    for (int k = 0; k < 20 && src_beat[1] != 2; k++) cycle();
    check("gap_reached_beat2", 128'(src_beat[1]), 128'(2));
    src_hold[1] = 1;
    drive_inputs();
    for (int k = 0; k < 5; k++) begin
      cycle();
      check($sformatf("gap_hold%0d", k), 128'({rr_grant, rr_busy, rr_s_ready[3]}),
            128'({2'd1, 1'b1, 1'b0}));
    end
    src_hold[1] = 0;
    drive_inputs();
    for (int k = 0; k < 40 && oq_data.size() < 5; k++) cycle();
    check("gap_count", 128'(oq_data.size() >= 5), 128'(1));
    for (int k = 0; k < 5 && k < oq_data.size(); k++) begin
      exp_d = (k < 4) ? {40'h0, 8'd1, 8'd0, 8'(k)} : {40'h0, 8'd3, 8'd0, 8'd0};
      check($sformatf("gap_beat%0d", k), 128'({oq_last[k], oq_data[k]}), 128'({k == 3, exp_d}));
    end

    // FIXED: channel 0 keeps re-requesting, channel 2 must wait.
    sel = 1;
    do_reset();
    start_src(0, 2, 0, 0);
    start_src(2, 2, 0, 0);
    drive_inputs();
    for (int k = 0; k < 24; k++) begin
      cycle();
      if (fx_busy) check($sformatf("fx_grant_c%0d", k), 128'(fx_grant), 128'(0));
    end
    cnt = 0;
    foreach (oq_data[k]) if (oq_data[k][23:16] == 8'd2) cnt++;
    check("fx_no_ch2", 128'(cnt), 128'(0));
    check("fx_ch0_beats", 128'(oq_data.size() >= 8), 128'(1));
    src_once[0] = 1;
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      cycle();
      if (oq_data.size() > 0 && oq_data[oq_data.size()-1][23:16] == 8'd2) seen = 1;
    end
    check("fx_ch2_after_release", 128'(seen), 128'(1));
    sel = 0;

    // Reset after two beats of a 4-beat packet.
    do_reset();
    start_src(0, 4, 1, 0);
    drive_inputs();
    for (int k = 0; k < 20 && src_beat[0] != 2; k++) cycle();
    check("mid_reached_beat2", 128'(src_beat[0]), 128'(2));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 128'(rr_valid), 128'(0));
    check("mid_rst_last", 128'(rr_last), 128'(0));
    check("mid_rst_busy", 128'(rr_busy), 128'(0));
    check("mid_rst_grant", 128'(rr_grant), 128'(0));
    check("mid_rst_data", 128'(rr_data), 128'(0));
    check("mid_rst_user_keep", 128'({rr_user, rr_keep}), 128'(0));
    check("mid_rst_ready", 128'(rr_s_ready), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    clear_sources();
    rst_n = 1'b1;
    start_src(0, 2, 1, 5);
    start_src(1, 2, 1, 5);
    drive_inputs();
    cycle();
    check("post_rst_grant", 128'({rr_grant, rr_busy}), 128'({2'd0, 1'b1}));
    for (int k = 0; k < 30 && oq_data.size() < 4; k++) cycle();
    check("post_rst_count", 128'(oq_data.size()), 128'(4));
    if (oq_data.size() >= 4) begin
      check("post_rst_b0", 128'({oq_last[0], oq_data[0]}), 128'({1'b0, 64'h0000_0000_0000_0500}));
      check("post_rst_b1", 128'({oq_last[1], oq_data[1]}), 128'({1'b1, 64'h0000_0000_0000_0501}));
      check("post_rst_b2", 128'({oq_last[2], oq_data[2]}), 128'({1'b0, 64'h0000_0000_0001_0500}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
